// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use and multiply/divide hilo hazard detection with stall generation and stall counting
//   clk, reset (async, active-high)
//   id_rs, id_rt, id_uses_rt            : decode-stage sources
//   ex_memtoreg, ex_regwrite, ex_rw      : EX-stage load/writeback info
//   md_start, md_is_div, id_reads_hilo   : mult/div issue and hilo reads from decode
//   stall_id, stall_ex                   : freeze IF/ID, bubble into EX
//   md_busy, md_done                     : unit running, one-cycle completion pulse
//   stall_count                          : saturating count of stalled cycles
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_memtoreg,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_rw,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        id_reads_hilo,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] stall_count_q;
  logic        lu, hh;
  logic [5:0]  load;
  assign lu   = ex_memtoreg && ex_regwrite && ex_rw != 5'd0 &&
                (ex_rw == id_rs || (id_uses_rt && ex_rw == id_rt));
  assign hh   = state_q == RUN && (id_reads_hilo || md_start);
  assign load = md_is_div ? 6'(DIV_CYCLES - 1) : 6'(MULT_CYCLES - 1);
  assign stall_id    = lu || hh;
  assign stall_ex    = lu || hh;
  assign md_busy     = busy_q;
  assign md_done     = done_q;
  assign stall_count = stall_count_q;
  // IDLE and DONE share the start decision: a start held through RUN is accepted in DONE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stall_count_q <= '0;
    end else begin
      stall_count_q <= (stall_id && ~&stall_count_q) ? stall_count_q + 32'd1 : stall_count_q;
      case (state_q)
        RUN:
          if (cnt_q == 6'd0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else cnt_q <= cnt_q - 6'd1;
        default: begin
          done_q <= 1'b0;
          if (md_start && !lu) begin
            state_q <= RUN;
            cnt_q   <= load;
            busy_q  <= 1'b1;
          end else state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks of hazard_stall_ctrl against a cycle-level reference model
module tb_hazard_stall_ctrl;
  localparam int MULT = 32, DIV = 34;
  logic clk = 0, reset = 1;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rw = 0;
  logic id_uses_rt = 0, ex_memtoreg = 0, ex_regwrite = 0;
  logic md_start = 0, md_is_div = 0, id_reads_hilo = 0;
  logic stall_id, stall_ex, md_busy, md_done;
  logic [31:0] stall_count;
  int n_cmp = 0, n_bad = 0;
  int busy_left, m_done, cyc, last_done, gap, busy_seen, done_seen;
  longint m_cnt;
  hazard_stall_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_rw(ex_rw),
    .md_start(md_start), .md_is_div(md_is_div), .id_reads_hilo(id_reads_hilo),
    .stall_id(stall_id), .stall_ex(stall_ex), .md_busy(md_busy), .md_done(md_done),
    .stall_count(stall_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  function automatic bit m_lu();
    return ex_memtoreg && ex_regwrite && ex_rw != 0 &&
           (ex_rw == id_rs || (id_uses_rt && ex_rw == id_rt));
  endfunction
  task automatic m_clear();
    busy_left = 0; m_done = 0; m_cnt = 0;
  endtask
  task automatic tick();
    bit lu, busy, st;
    #1;
    lu   = m_lu();
    busy = busy_left > 0;
    st   = lu || (busy && (id_reads_hilo || md_start));
    chk("stall_id", {31'd0, stall_id}, {31'd0, st});
    chk("stall_ex", {31'd0, stall_ex}, {31'd0, st});
    chk("md_busy", {31'd0, md_busy}, {31'd0, busy});
    chk("md_done", {31'd0, md_done}, 32'(m_done));
    chk("stall_count", stall_count, 32'(m_cnt));
    if (md_busy) busy_seen++;
    if (md_done) begin
      done_seen++;
      if (last_done >= 0) gap = cyc - last_done;
      last_done = cyc;
    end
    cyc++;
    @(posedge clk);
    if (st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    m_done = (busy_left == 1);
    if (busy) busy_left--;
    else if (md_start && !lu) busy_left = md_is_div ? DIV : MULT;
    @(negedge clk);
  endtask
  task automatic do_reset();
    reset = 1;
    {id_rs, id_rt, ex_rw, id_uses_rt, ex_memtoreg, ex_regwrite, md_start, md_is_div, id_reads_hilo} = '0;
    m_clear();
    #1;
    chk("rst_busy", {31'd0, md_busy}, 0);
    chk("rst_done", {31'd0, md_done}, 0);
    chk("rst_count", stall_count, 0);
    @(negedge clk);
    reset = 0;
    busy_seen = 0; done_seen = 0; last_done = -1; gap = 0;
  endtask
  initial begin
    cyc = 0;
    @(negedge clk);
    do_reset();
    ex_memtoreg = 1; ex_regwrite = 1; ex_rw = 5; id_rs = 5;
    tick();
    ex_memtoreg = 0; ex_regwrite = 0;
    tick();
    chk("lu_count", stall_count, 1);
    do_reset();
    ex_memtoreg = 1; ex_regwrite = 1; ex_rw = 0; id_rs = 0;
    tick();
    chk("r0_count", stall_count, 0);
    do_reset();
    md_start = 1;
    tick();
    md_start = 0;
    repeat (36) tick();
    chk("mult_busy_cycles", busy_seen, MULT);
    chk("mult_done_pulses", done_seen, 1);
    do_reset();
    md_start = 1; md_is_div = 1;
    tick();
    md_start = 0;
    tick();
    id_reads_hilo = 1;
    repeat (40) tick();
    chk("hilo_count", stall_count, 33);
    do_reset();
    md_start = 1;
    repeat (70) tick();
    chk("b2b_gap", gap, 33);
    do_reset();
    md_start = 1;
    tick();
    md_start = 0;
    repeat (21) tick();
    #2 reset = 1;
    m_clear();
    #1;
    chk("midrst_busy", {31'd0, md_busy}, 0);
    chk("midrst_count", stall_count, 0);
    @(negedge clk);
    reset = 0;
    done_seen = 0;
    repeat (40) tick();
    chk("midrst_no_done", done_seen, 0);
    do_reset();
    repeat (3000) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rw = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      ex_memtoreg = ($urandom_range(0, 3) == 0);
      ex_regwrite = 1'($urandom);
      md_start = ($urandom_range(0, 7) == 0);
      md_is_div = 1'($urandom);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
